// File: rtl/mmio_port_responder.sv
// rtl/mmio_port_responder.sv - MMIO responder: output port, synced input port, timer (MMIO_TIMER_EN)
module mmio_port_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [7:0]  PortIn,
  output logic [31:0] ReadData,
  output logic        Hit,
  output logic [31:0] PortOut,
  output logic        Event
);

  localparam logic [2:0] OFS_PORTOUT = 3'd0;
  localparam logic [2:0] OFS_PORTIN  = 3'd1;
  localparam logic [2:0] OFS_STATUS  = 3'd2;
  localparam logic [2:0] OFS_TLOAD   = 3'd3;
  localparam logic [2:0] OFS_TCOUNT  = 3'd4;

  logic [2:0]  sel;
  logic        wr_en;
  logic        addr_unused;
  logic [7:0]  sync1;
  logic [7:0]  sync2;
  logic [7:0]  prev;
  logic [1:0]  status;
  logic [1:0]  status_next;
  logic [1:0]  w1c_mask;
  logic        chg_set;
  logic        exp_set;
  logic [31:0] rd_mux;

  // Word-granular decode: the two byte-lane bits never select anything.
  assign Hit         = (Address[31:5] == BASE_ADDR[31:5]);
  assign sel         = Address[4:2];
  assign wr_en       = Hit & MemWrite;
  assign addr_unused = ^Address[1:0];

  // Output port register, updated by stores to offset 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PortOut <= 32'h0;
    end else if (wr_en && (sel == OFS_PORTOUT)) begin
      PortOut <= WriteData;
    end
  end

  // Two-flop synchronizer plus one history stage for change detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 8'h0;
      sync2 <= 8'h0;
      prev  <= 8'h0;
    end else begin
      sync1 <= PortIn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign chg_set = (sync2 != prev);

`ifdef MMIO_TIMER_EN
  logic [31:0] load_q;
  logic [31:0] count_q;
  logic [31:0] load_next;
  logic [31:0] count_next;
  logic        tload_wr;

  assign tload_wr = wr_en && (sel == OFS_TLOAD);
  // Expiry is the reload point of the countdown; a simultaneous load write
  // still reports it.
  assign exp_set  = (count_q == 32'd1);

  // Timer next state: decrement, reload at 1, idle at 0; a load write overrides.
  always_comb begin
    load_next  = load_q;
    count_next = count_q;
    if (count_q > 32'd1) begin
      count_next = count_q - 32'd1;
    end else if (count_q == 32'd1) begin
      count_next = load_q;
    end
    if (tload_wr) begin
      load_next  = WriteData;
      count_next = WriteData;
    end
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_q  <= 32'h0;
      count_q <= 32'h0;
    end else begin
      load_q  <= load_next;
      count_q <= count_next;
    end
  end
`else
  assign exp_set = 1'b0;
`endif

  // Sticky flags: W1C clears first, then set events are OR'd in so a set
  // on the same edge as a clear wins.
  always_comb begin
    w1c_mask = 2'b00;
    if (wr_en && (sel == OFS_STATUS)) begin
      w1c_mask = WriteData[1:0];
    end
    status_next = (status & ~w1c_mask) | {exp_set, chg_set};
  end

  // Status flags and the event line, both loaded from the same next-state
  // value so Event never lags STATUS.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      status <= 2'b00;
      Event  <= 1'b0;
    end else begin
      status <= status_next;
      Event  <= |status_next;
    end
  end

  // Load data mux from current register state; gated by Hit && MemRead.
  always_comb begin
    rd_mux = 32'h0;
    case (sel)
      OFS_PORTOUT: rd_mux = PortOut;
      OFS_PORTIN:  rd_mux = {24'h0, sync2};
      OFS_STATUS:  rd_mux = {30'h0, status};
`ifdef MMIO_TIMER_EN
      OFS_TLOAD:   rd_mux = load_q;
      OFS_TCOUNT:  rd_mux = count_q;
`endif
      default:     rd_mux = 32'h0;
    endcase
    ReadData = (Hit && MemRead) ? rd_mux : 32'h0;
  end

endmodule

// File: doc/mmio_port_responder.md
# mmio_port_responder

Memory-mapped I/O responder on the MIPS processor's data-memory bus. It decodes word loads and stores that fall inside a 32-byte window and services them alongside the data RAM. It provides:
- a registered 32-bit output port;
- a synchronized 8-bit input port with sticky change detection;
- a periodic down-counting timer.

The top level uses `Hit` to select between this block's `ReadData` and the data RAM's `ReadData`.

## Interface

Parameters:
- `BASE_ADDR`, default 32'h1001_0400 — window base; must be 32-byte aligned. Decode uses `Address[31:5]` only.

Ports:
- `clk`  in  1  — processor clock; all state updates on the rising edge.
- `reset`  in  1  — asynchronous, active-low; clears all state.
- `Address`  in  32  — byte address from the ALU result.
- `WriteData`  in  32  — store data (rt value).
- `MemWrite`  in  1  — store strobe, sampled at the rising edge.
- `MemRead`  in  1  — load strobe; qualifies `ReadData`.
- `PortIn`  in  8  — asynchronous external input.
- `ReadData`  out  32  — combinational load data.
- `Hit`  out  1  — combinational; `Address[31:5] == BASE_ADDR[31:5]`.
- `PortOut`  out  32  — registered output port.
- `Event`  out  1  — registered; equals OR of `STATUS[1:0]`.

## Operation

- Register select is `Address[4:2]` (bits [1:0] are ignored):
  - 0: `PORTOUT`, RW.
  - 1: `PORTIN`, RO; value is `{24'b0, sync2}`.
  - 2: `STATUS`, write-1-to-clear. Bit 0 is CHG (input changed), bit 1 is EXP (timer expired); bits [31:2] read 0.
  - 3: `TIMER_LOAD`, RW.
  - 4: `TIMER_COUNT`, RO.
  - 5–7: reserved; read 0, writes ignored.
- Store: when `Hit && MemWrite`, the selected register updates at the rising edge. Writes to RO or reserved offsets are dropped.
- Load: `ReadData` = selected register when `Hit && MemRead`, else 32'h0. It is purely combinational from current register state, so a single-cycle `lw` completes in the same cycle.
- `MemRead` and `MemWrite` both asserted: the write is performed; `ReadData` shows the pre-write value.
- Input path: two-flop synchronizer `PortIn -> sync1 -> sync2`, plus history register `prev <= sync2`.
  - CHG is set on any edge where `sync2 != prev`.
- Timer: 32-bit down counter `count` with reload register `load`.
  - Write to `TIMER_LOAD`: `load <= WriteData`, `count <= WriteData`.
  - `count > 1`: decrement.
  - `count == 1`: `count <= load` and EXP is set.
  - `count == 0`: idle.
  - Writing 0 stops the timer. Period = `load` cycles.
- Sticky flag priority: if a set event and a W1C of the same bit occur on the same edge, set wins (the bit stays 1).
- `Event` is registered from the next-state `STATUS` value, so it tracks `STATUS` with no extra delay.

## Timing

- Reset values (async assert): `PortOut` = 0, `sync1`/`sync2`/`prev` = 0, `STATUS` = 0, `load` = 0, `count` = 0, `Event` = 0. `Hit` and `ReadData` follow inputs combinationally.
- Reset asserted mid-operation aborts the timer and clears flags immediately, with no clock needed.
- Store to `PORTOUT`: new value appears on `PortOut` right after the store's rising edge (1-cycle latency).
- `PortIn` change:
  - visible in `PORTIN` after the 2nd rising edge;
  - CHG and `Event` set after the 3rd rising edge.
- A nonzero `PortIn` at reset release therefore sets CHG after 3 edges.
- Timer: a write of N at edge E0 sets EXP at edge E0+N, then every N edges thereafter.
- A `TIMER_LOAD` write on the same edge as an expiry: the written value wins for `count`/`load`, and EXP is still set.
- `count` wraps never. Decrement stops at the reload point; there is no underflow.

## Configuration

- `MMIO_TIMER_EN` defined: timer logic present as described.
- `MMIO_TIMER_EN` undefined:
  - `load`/`count` are not built;
  - offsets 3 and 4 behave as reserved (read 0, writes ignored);
  - `STATUS[1]` is tied to 0;
  - `Event` reflects CHG only.

## Test plan

- Reset, then store 32'hDEAD_BEEF to `BASE_ADDR+0` -> `PortOut` = 32'hDEADBEEF after that edge; `lw BASE_ADDR+0` returns it; `lw BASE_ADDR+0x20` gives `Hit` = 0, `ReadData` = 0.
- `PortIn` 8'h00→8'h5A between edges -> `PORTIN` reads 32'h5A after 2 edges, `STATUS` = 1 and `Event` = 1 after 3; store 32'h1 to `STATUS` -> `STATUS` = 0, `Event` = 0.
- Store 5 to `TIMER_LOAD` -> `TIMER_COUNT` reads 5,4,3,2,1; EXP set on the 5th edge; count reloads to 5; EXP set again 5 edges later; store 0 -> count holds 0, no further EXP.
- W1C of CHG on the same edge that a new `PortIn` change reaches `prev` comparison -> CHG remains 1.
- Assert `reset` low asynchronously mid-countdown with CHG set -> `PortOut`, `STATUS`, `count`, `Event` all 0 before the next clock edge; timer stays idle after release.
- Store to offsets 1 and 5 with 32'hFFFF_FFFF -> no register changes; reads of offset 5 return 0; simultaneous `MemRead`+`MemWrite` to `PORTOUT` returns the old value that cycle.
